// File: rtl/date_field_adjuster_if.sv
// Date-edit bus between the adjust-selection controller, the date editor and the RTC write path.
interface date_field_adjuster_if;
    logic       a_dia;
    logic       a_mes;
    logic       a_year;
    logic       inc;
    logic       dec;
    logic       load;
    logic [7:0] day_in;
    logic [7:0] month_in;
    logic [7:0] year_in;
    logic       wr_ack;
    logic [7:0] day_bcd;
    logic [7:0] month_bcd;
    logic [7:0] year_bcd;
    logic       wr_req;
    logic [1:0] wr_field;
    logic [7:0] wr_data;
    logic       busy;

    modport master (
        output a_dia, a_mes, a_year, inc, dec, load, day_in, month_in, year_in, wr_ack,
        input  day_bcd, month_bcd, year_bcd, wr_req, wr_field, wr_data, busy
    );

    modport slave (
        input  a_dia, a_mes, a_year, inc, dec, load, day_in, month_in, year_in, wr_ack,
        output day_bcd, month_bcd, year_bcd, wr_req, wr_field, wr_data, busy
    );
endinterface

// File: rtl/date_field_adjuster.sv
// BCD day/month/year editor with calendar wrap and day clamping.
// Every changed field, plus any clamped day, is pushed out through wr_req/wr_ack.
module date_field_adjuster #(
    parameter logic [7:0] DAY_RST  = 8'h01,
    parameter logic [7:0] MON_RST  = 8'h01,
    parameter logic [7:0] YEAR_RST = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    date_field_adjuster_if.slave bus
);

    localparam int unsigned BCD_W   = 8;
    localparam int unsigned FIELD_W = 2;

    localparam logic [FIELD_W-1:0] FLD_DAY  = 2'd0;
    localparam logic [FIELD_W-1:0] FLD_MON  = 2'd1;
    localparam logic [FIELD_W-1:0] FLD_YEAR = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_FIELD = 2'd1,
        WR_DAY   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   day_q, day_d;
    logic [BCD_W-1:0]   mon_q, mon_d;
    logic [BCD_W-1:0]   year_q, year_d;
    logic               wr_req_q, wr_req_d;
    logic [FIELD_W-1:0] wr_field_q, wr_field_d;
    logic [BCD_W-1:0]   wr_data_q, wr_data_d;
    logic               clamp_q, clamp_d;
    logic               busy_q;

    // Year is passed as tens[0] and units[1:0]: (10*t + u) mod 4 == (2*t[0] + u) mod 4.
    function automatic logic [7:0] max_day(input logic [7:0] m, input logic y_t0,
                                           input logic [1:0] y_u);
        logic [1:0] r;
        r = {y_t0, 1'b0} + y_u;
        case (m)
            8'h04, 8'h06, 8'h09, 8'h11: max_day = 8'h30;
            8'h02:                      max_day = (r == 2'd0) ? 8'h29 : 8'h28;
            default:                    max_day = 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
        else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v);
        bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    logic             sel_ok, dir_ok, edit_ok;
    logic [BCD_W-1:0] lim_cur, day_edit, mon_edit, year_edit;
    logic [BCD_W-1:0] lim_mon, lim_year;
    logic [BCD_W-1:0] ld_mon, ld_year, ld_lim, ld_day;

    // Candidate values for an edit and for a load; the FSM picks which one lands.
    always_comb begin
        sel_ok  = ({bus.a_year, bus.a_mes, bus.a_dia} == 3'b001) ||
                  ({bus.a_year, bus.a_mes, bus.a_dia} == 3'b010) ||
                  ({bus.a_year, bus.a_mes, bus.a_dia} == 3'b100);
        dir_ok  = bus.inc ^ bus.dec;
        edit_ok = sel_ok && dir_ok;

        lim_cur = max_day(mon_q, year_q[4], year_q[1:0]);
        if (bus.inc) day_edit = (day_q >= lim_cur) ? 8'h01 : bcd_inc(day_q);
        else         day_edit = (day_q <= 8'h01) ? lim_cur : bcd_dec(day_q);

        if (bus.inc) mon_edit = (mon_q >= 8'h12) ? 8'h01 : bcd_inc(mon_q);
        else         mon_edit = (mon_q <= 8'h01) ? 8'h12 : bcd_dec(mon_q);

        if (bus.inc) year_edit = (year_q >= 8'h99) ? 8'h00 : bcd_inc(year_q);
        else         year_edit = (year_q == 8'h00) ? 8'h99 : bcd_dec(year_q);

        lim_mon  = max_day(mon_edit, year_q[4], year_q[1:0]);
        lim_year = max_day(mon_q, year_edit[4], year_edit[1:0]);

        ld_mon  = (bcd_ok(bus.month_in) && bus.month_in != 8'h00 && bus.month_in <= 8'h12)
                  ? bus.month_in : MON_RST;
        ld_year = bcd_ok(bus.year_in) ? bus.year_in : YEAR_RST;
        ld_lim  = max_day(ld_mon, ld_year[4], ld_year[1:0]);
        ld_day  = (bcd_ok(bus.day_in) && bus.day_in != 8'h00 && bus.day_in <= ld_lim)
                  ? bus.day_in : DAY_RST;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        day_d      = day_q;
        mon_d      = mon_q;
        year_d     = year_q;
        wr_req_d   = wr_req_q;
        wr_field_d = wr_field_q;
        wr_data_d  = wr_data_q;
        clamp_d    = clamp_q;

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    day_d  = ld_day;
                    mon_d  = ld_mon;
                    year_d = ld_year;
                end else if (edit_ok) begin
                    wr_req_d = 1'b1;
                    state_d  = WR_FIELD;
                    if (bus.a_dia) begin
                        day_d      = day_edit;
                        wr_field_d = FLD_DAY;
                        wr_data_d  = day_edit;
                    end else if (bus.a_mes) begin
                        mon_d      = mon_edit;
                        wr_field_d = FLD_MON;
                        wr_data_d  = mon_edit;
                        if (day_q > lim_mon) begin
                            day_d   = lim_mon;
                            clamp_d = 1'b1;
                        end
                    end else begin
                        year_d     = year_edit;
                        wr_field_d = FLD_YEAR;
                        wr_data_d  = year_edit;
                        if (day_q > lim_year) begin
                            day_d   = lim_year;
                            clamp_d = 1'b1;
                        end
                    end
                end
            end
            WR_FIELD: begin
                if (bus.wr_ack) begin
                    if (clamp_q) begin
                        wr_field_d = FLD_DAY;
                        wr_data_d  = day_q;
                        state_d    = WR_DAY;
                    end else begin
                        wr_req_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            WR_DAY: begin
                if (bus.wr_ack) begin
                    wr_req_d = 1'b0;
                    clamp_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                wr_req_d = 1'b0;
                clamp_d  = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            day_q      <= DAY_RST;
            mon_q      <= MON_RST;
            year_q     <= YEAR_RST;
            wr_req_q   <= 1'b0;
            wr_field_q <= FLD_DAY;
            wr_data_q  <= 8'h00;
            clamp_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            day_q      <= day_d;
            mon_q      <= mon_d;
            year_q     <= year_d;
            wr_req_q   <= wr_req_d;
            wr_field_q <= wr_field_d;
            wr_data_q  <= wr_data_d;
            clamp_q    <= clamp_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign bus.day_bcd   = day_q;
    assign bus.month_bcd = mon_q;
    assign bus.year_bcd  = year_q;
    assign bus.wr_req    = wr_req_q;
    assign bus.wr_field  = wr_field_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_date_field_adjuster.sv
// Directed bench for date_field_adjuster: edits, clamps, wraps, ignored inputs, load checks, reset.
module tb_date_field_adjuster;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    date_field_adjuster_if dif ();

    date_field_adjuster dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dif.a_dia = 0; dif.a_mes = 0; dif.a_year = 0;
        dif.inc = 0; dif.dec = 0; dif.load = 0; dif.wr_ack = 0;
    endtask

    task automatic do_load(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
        dif.day_in = d; dif.month_in = m; dif.year_in = y; dif.load = 1;
        tick();
        dif.load = 0;
    endtask

    task automatic do_edit(input logic [2:0] sel, input logic i, input logic d);
        {dif.a_year, dif.a_mes, dif.a_dia} = sel;
        dif.inc = i; dif.dec = d;
        tick();
        idle_inputs();
    endtask

    task automatic do_ack();
        dif.wr_ack = 1;
        tick();
        dif.wr_ack = 0;
    endtask

    task automatic check_date(input string tag, input logic [7:0] d, input logic [7:0] m,
                              input logic [7:0] y);
        check({tag, "_day"},  32'(dif.day_bcd),   32'(d));
        check({tag, "_mon"},  32'(dif.month_bcd), 32'(m));
        check({tag, "_year"}, 32'(dif.year_bcd),  32'(y));
    endtask

    task automatic check_wr(input string tag, input logic req, input logic [1:0] fld,
                            input logic [7:0] data);
        check({tag, "_req"}, 32'(dif.wr_req), 32'(req));
        if (req) begin
            check({tag, "_fld"},  32'(dif.wr_field), 32'(fld));
            check({tag, "_data"}, 32'(dif.wr_data),  32'(data));
        end
        check({tag, "_busy"}, 32'(dif.busy), 32'(req));
    endtask

    localparam logic [2:0] S_DIA  = 3'b001;
    localparam logic [2:0] S_MES  = 3'b010;
    localparam logic [2:0] S_YEAR = 3'b100;

    initial begin
        idle_inputs();
        dif.day_in = 8'h00; dif.month_in = 8'h00; dif.year_in = 8'h00;
        rst = 1;
        tick(); tick();
        rst = 0;
        check_date("rst", 8'h01, 8'h01, 8'h00);
        check("rst_req", 32'(dif.wr_req), 32'd0);
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_fld", 32'(dif.wr_field), 32'd0);
        check("rst_data", 32'(dif.wr_data), 32'd0);

        // Day dec wrap at 01 in January, write held without ack, inc dropped while busy.
        do_edit(S_DIA, 0, 1);
        check_date("daydec", 8'h31, 8'h01, 8'h00);
        check_wr("daydec_w", 1, 2'd0, 8'h31);
        tick(); tick();
        check_wr("daydec_hold", 1, 2'd0, 8'h31);
        do_edit(S_DIA, 1, 0);
        check_date("busy_inc", 8'h31, 8'h01, 8'h00);
        check_wr("busy_inc_w", 1, 2'd0, 8'h31);
        do_ack();
        check_wr("daydec_done", 0, 2'd0, 8'h00);
        tick();
        check_wr("daydec_idle", 0, 2'd0, 8'h00);

        // Month clamp: 31/01/23 -> 28/02/23 with two writes.
        do_load(8'h31, 8'h01, 8'h23);
        check_date("ld1", 8'h31, 8'h01, 8'h23);
        check_wr("ld1_w", 0, 2'd0, 8'h00);
        do_edit(S_MES, 1, 0);
        check_date("clampm", 8'h28, 8'h02, 8'h23);
        check_wr("clampm_w1", 1, 2'd1, 8'h02);
        do_ack();
        check_wr("clampm_w2", 1, 2'd0, 8'h28);
        tick();
        check_wr("clampm_w2hold", 1, 2'd0, 8'h28);
        do_ack();
        check_wr("clampm_done", 0, 2'd0, 8'h00);

        // Year clamp out of a leap year: 29/02/24 -> 28/02/23.
        do_load(8'h29, 8'h02, 8'h24);
        check_date("ld2", 8'h29, 8'h02, 8'h24);
        do_edit(S_YEAR, 0, 1);
        check_date("clampy", 8'h28, 8'h02, 8'h23);
        check_wr("clampy_w1", 1, 2'd2, 8'h23);
        do_ack();
        check_wr("clampy_w2", 1, 2'd0, 8'h28);
        do_ack();
        check_wr("clampy_done", 0, 2'd0, 8'h00);

        // Year 00 dec wraps to 99, no clamp.
        do_load(8'h15, 8'h06, 8'h00);
        do_edit(S_YEAR, 0, 1);
        check_date("yrwrap", 8'h15, 8'h06, 8'h99);
        check_wr("yrwrap_w", 1, 2'd2, 8'h99);
        do_ack();
        check_wr("yrwrap_done", 0, 2'd0, 8'h00);

        // BCD carry on day inc: 09 -> 10.
        do_load(8'h09, 8'h06, 8'h99);
        do_edit(S_DIA, 1, 0);
        check_date("carry", 8'h10, 8'h06, 8'h99);
        check_wr("carry_w", 1, 2'd0, 8'h10);
        do_ack();

        // Leap February day dec wraps 01 -> 29.
        do_load(8'h01, 8'h02, 8'h24);
        do_edit(S_DIA, 0, 1);
        check_date("leapwrap", 8'h29, 8'h02, 8'h24);
        do_ack();
        check_wr("leapwrap_done", 0, 2'd0, 8'h00);

        // Ignored edits: both directions, two fields.
        do_load(8'h10, 8'h06, 8'h99);
        do_edit(S_DIA, 1, 1);
        check_date("incdec", 8'h10, 8'h06, 8'h99);
        check_wr("incdec_w", 0, 2'd0, 8'h00);
        do_edit(S_DIA | S_MES, 1, 0);
        check_date("twosel", 8'h10, 8'h06, 8'h99);
        check_wr("twosel_w", 0, 2'd0, 8'h00);

        // Invalid load fields fall back to reset values.
        do_load(8'h45, 8'h13, 8'h57);
        check_date("badld", 8'h01, 8'h01, 8'h57);
        do_load(8'h1A, 8'h02, 8'h3A);
        check_date("badbcd", 8'h01, 8'h02, 8'h00);

        // Load wins over a simultaneous edit and issues no write.
        dif.a_dia = 1; dif.inc = 1;
        do_load(8'h05, 8'h05, 8'h05);
        idle_inputs();
        check_date("ldwin", 8'h05, 8'h05, 8'h05);
        check_wr("ldwin_w", 0, 2'd0, 8'h00);

        // Reset while waiting in WR_DAY discards the pending clamp write.
        do_load(8'h31, 8'h01, 8'h23);
        do_edit(S_MES, 1, 0);
        do_ack();
        check_wr("pre_rst", 1, 2'd0, 8'h28);
        rst = 1;
        tick();
        rst = 0;
        check_date("rst2", 8'h01, 8'h01, 8'h00);
        check_wr("rst2_w", 0, 2'd0, 8'h00);
        do_ack();
        tick();
        check_wr("rst2_after", 0, 2'd0, 8'h00);
        check_date("rst2_after", 8'h01, 8'h01, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/date_field_adjuster.md
Name: date_field_adjuster

Overview:
- Consumes the one-hot field-select strobes (a_dia, a_mes, a_year) and the increment/decrement pulses from the date adjust-selection controller.
- Edits the held date value (day, month, year, all BCD) with calendar-correct wrap-around and clamping.
- Pushes every changed field to the RTC write path through a req/ack handshake.
- Sits between the date-parameter selector and the RTC interface controller.

Parameters:
- DAY_RST, 8'h01, BCD day value after reset and after invalid load
- MON_RST, 8'h01, BCD month value after reset and after invalid load
- YEAR_RST, 8'h00, BCD year value (20xx) after reset and after invalid load

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- a_dia  in  1  day field selected
- a_mes  in  1  month field selected
- a_year  in  1  year field selected
- inc  in  1  single-cycle increment pulse (debounced upstream)
- dec  in  1  single-cycle decrement pulse (debounced upstream)
- load  in  1  capture day_in/month_in/year_in
- day_in  in  8  BCD day read from RTC
- month_in  in  8  BCD month read from RTC
- year_in  in  8  BCD year read from RTC
- wr_ack  in  1  RTC path accepted current write
- day_bcd  out  8  current day, BCD 01..31
- month_bcd  out  8  current month, BCD 01..12
- year_bcd  out  8  current year, BCD 00..99
- wr_req  out  1  write request pending
- wr_field  out  2  0 = day, 1 = month, 2 = year
- wr_data  out  8  BCD value to write
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, wins over everything):
  - day/month/year = DAY_RST/MON_RST/YEAR_RST
  - wr_req = 0, wr_field = 0, wr_data = 0, busy = 0
  - state = IDLE; any pending clamp write is discarded.
- max_day(m, y):
  - 31 for months 1, 3, 5, 7, 8, 10, 12
  - 30 for months 4, 6, 9, 11
  - February: 29 if y mod 4 == 0, else 28 (00 counts as leap)
- Edit acceptance:
  - Accepted only in IDLE.
  - Requires exactly one of a_dia/a_mes/a_year high.
  - Requires exactly one of inc/dec high.
  - Otherwise the edit is ignored: no value change, no write.
- Day edit: inc at max_day wraps to 01, else +1; dec at 01 wraps to max_day, else -1.
- Month edit: 12 -> 01 on inc, 01 -> 12 on dec.
- Year edit: 99 -> 00 on inc, 00 -> 99 on dec.
- Clamp:
  - Applies after a month or year edit.
  - If day > max_day(new month, new year), day is set to max_day in the same edge as the field update.
  - A pending clamp-write flag is set.
- Arithmetic: all arithmetic in BCD; the low nibble wraps 9 -> 0 with carry and 0 -> 9 with borrow.
- Latency: an edit accepted at edge N updates the outputs at edge N; at the same edge, wr_req = 1, wr_field = edited field, wr_data = new value, state = WR_FIELD.
- FSM IDLE / WR_FIELD / WR_DAY:
  - WR_FIELD: wr_req, wr_field and wr_data are held stable until wr_ack is sampled high.
    - On ack with no pending clamp: wr_req = 0, go to IDLE.
    - On ack with a pending clamp: wr_field = 0, wr_data = day, wr_req stays 1, go to WR_DAY.
  - WR_DAY: hold until wr_ack; then wr_req = 0, clear the clamp flag, go to IDLE.
  - wr_ack while wr_req = 0 is ignored.
- Load:
  - Accepted only in IDLE; when load and an edit occur in the same cycle, load wins.
  - Each field is range-checked: valid BCD digits, month 01..12, year 00..99, day 01..max_day(loaded month, loaded year).
  - An invalid field takes its *_RST value; the day check uses the month/year after that substitution.
  - Load never issues a write.
- Inc/dec pulses and load received while busy are dropped, not queued.

Test Plan:
- Reset with rst = 1 for 2 cycles -> day/month/year = 01/01/00, wr_req = 0, busy = 0.
- Edit from 01/01/00: a_dia = 1, dec pulse -> day 0x31; wr_req = 1, wr_field = 0, wr_data = 0x31 held until wr_ack; wr_req low the next cycle.
- Clamp: load 31/01/23, then a_mes = 1, inc -> month 0x02 and day 0x28 in the same edge; write {1, 0x02}, then after ack write {0, 0x28}, then after ack wr_req = 0.
- Leap year and wrap:
  - 29/02/24, a_year = 1, dec -> year 0x23, day 0x28, two writes.
  - Year 00 with dec -> 0x99.
  - Day 0x09 with inc -> 0x10.
- Ignored inputs:
  - inc and dec in the same cycle -> no change.
  - a_dia and a_mes both high -> no change.
  - inc during WR_FIELD -> dropped, values unchanged.
  - load of day 0x45 / month 0x13 -> 01/01 with the loaded year kept.
- Reset during WR_DAY -> next cycle wr_req = 0, state IDLE, values 01/01/00; no residual write occurs after release.
